// File: rtl/pc_pkg.sv
// pc_pkg: shared constants and types for the F-stage program-counter unit.
//   PC_DEF_*  : default reset PC, exception vector and legal fetch window.
//   pc_state_e: redirect-buffer FSM state (RUN / PEND).
package pc_pkg;

  localparam int unsigned PC_DEF_WIDTH      = 32;
  localparam logic [31:0] PC_DEF_RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] PC_DEF_EXC_VECTOR = 32'h0000_4180;
  localparam logic [31:0] PC_DEF_TEXT_BASE  = 32'h0000_3000;
  localparam logic [31:0] PC_DEF_TEXT_SIZE  = 32'h0000_4000;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_addr_check.sv
// pc_addr_check: combinational instruction-fetch address check (AdEL).
//   addr : candidate fetch address
//   exc  : 1 when addr is not word aligned or lies outside
//          [TEXT_BASE, TEXT_BASE + TEXT_SIZE)
module pc_addr_check
  import pc_pkg::*;
#(
  parameter int unsigned          WIDTH     = PC_DEF_WIDTH,
  parameter logic [WIDTH-1:0]     TEXT_BASE = WIDTH'(PC_DEF_TEXT_BASE),
  parameter logic [WIDTH-1:0]     TEXT_SIZE = WIDTH'(PC_DEF_TEXT_SIZE)
) (
  input  logic [WIDTH-1:0] addr,
  output logic             exc
);

  // One extra bit so a window reaching the top of the address space
  // does not wrap to a small end value.
  localparam logic [WIDTH:0] TEXT_END = {1'b0, TEXT_BASE} + {1'b0, TEXT_SIZE};

  logic misaligned;
  logic below_base;
  logic past_end;

  assign misaligned = |addr[1:0];
  assign below_base = addr < TEXT_BASE;
  assign past_end   = {1'b0, addr} >= TEXT_END;
  assign exc        = misaligned | below_base | past_end;

endmodule

// File: rtl/pc_unit.sv
// pc_unit: F-stage program counter with prioritised next-PC selection.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   stall      : freeze F stage
//   br_req     : taken branch/jump (one cycle), target on br_target
//   exc_req    : exception flush -> EXC_VECTOR
//   eret_req   : ERET flush -> epc
//   pc         : current fetch address (flop)
//   pend       : a redirect captured during a stall is waiting (flop)
//   fetch_exc  : AdEL on current pc (flop)
// Build option: define PC_RANGE_CHECK_EN to generate the alignment/window
// check; otherwise fetch_exc is tied to 0 and TEXT_BASE/TEXT_SIZE are unused.
//
// state | meaning
// RUN   | no buffered redirect; pc follows requests or increments
// PEND  | a branch arrived while stalled; pend_target_q is fetched on
//       | the first non-stalled edge unless overridden
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH      = PC_DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(PC_DEF_RESET_PC),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(PC_DEF_EXC_VECTOR),
  parameter logic [WIDTH-1:0] TEXT_BASE  = WIDTH'(PC_DEF_TEXT_BASE),
  parameter logic [WIDTH-1:0] TEXT_SIZE  = WIDTH'(PC_DEF_TEXT_SIZE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_req,
  input  logic [WIDTH-1:0] br_target,
  input  logic             exc_req,
  input  logic             eret_req,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] pc,
  output logic             pend,
  output logic             fetch_exc
);

  pc_state_e        state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             fetch_exc_q, fetch_exc_d;

  // Reset is folded into the next-state logic so that the address check
  // below sees RESET_PC on a reset edge as well.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    pend_target_d = pend_target_q;
    if (reset) begin
      state_d       = RUN;
      pc_d          = RESET_PC;
      pend_target_d = '0;
    end else if (exc_req) begin
      state_d = RUN;
      pc_d    = EXC_VECTOR;
    end else if (eret_req) begin
      state_d = RUN;
      pc_d    = epc;
    end else if (stall) begin
      if (br_req) begin
        state_d       = PEND;
        pend_target_d = br_target;
      end
    end else if (br_req) begin
      // A fresh branch beats an older buffered one.
      state_d = RUN;
      pc_d    = br_target;
    end else if (state_q == PEND) begin
      state_d = RUN;
      pc_d    = pend_target_q;
    end else begin
      pc_d = pc_q + WIDTH'(4);
    end
  end

`ifdef PC_RANGE_CHECK_EN
  pc_addr_check #(
    .WIDTH     (WIDTH),
    .TEXT_BASE (TEXT_BASE),
    .TEXT_SIZE (TEXT_SIZE)
  ) u_addr_check (
    .addr (pc_d),
    .exc  (fetch_exc_d)
  );
`else
  logic unused_cfg;
  assign unused_cfg  = ^{TEXT_BASE, TEXT_SIZE};
  assign fetch_exc_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    pc_q          <= pc_d;
    pend_target_q <= pend_target_d;
    fetch_exc_q   <= fetch_exc_d;
  end

  assign pc        = pc_q;
  assign pend      = (state_q == PEND);
  assign fetch_exc = fetch_exc_q;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector bench for pc_unit. Each table row is applied
// for one clock and the registered outputs are compared after the edge.
// The fetch_exc expectation follows PC_RANGE_CHECK_EN (0 when undefined).
module tb_pc_unit;

`ifdef PC_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        br_req;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] pc;
  logic        pend;
  logic        fetch_exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_unit dut (
    .clk       (clk),
    .reset     (reset),
    .stall     (stall),
    .br_req    (br_req),
    .br_target (br_target),
    .exc_req   (exc_req),
    .eret_req  (eret_req),
    .epc       (epc),
    .pc        (pc),
    .pend      (pend),
    .fetch_exc (fetch_exc)
  );

  typedef struct {
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_fexc;   // value when the range check is built in
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic s, input logic b, input logic [31:0] t,
                              input logic x, input logic e, input logic [31:0] ep,
                              input logic [31:0] xp, input logic xpend, input logic xf);
    vec_t v;
    v.stall = s; v.br = b; v.tgt = t; v.exc = x; v.eret = e; v.epc = ep;
    v.exp_pc = xp; v.exp_pend = xpend; v.exp_fexc = xf;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] xp, input logic xpend,
                           input logic xf);
    check({tag, " pc"}, pc, xp);
    check({tag, " pend"}, {31'b0, pend}, {31'b0, xpend});
    check({tag, " fetch_exc"}, {31'b0, fetch_exc}, {31'b0, xf & RC});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; br_req = 1'b0; br_target = '0;
    exc_req = 1'b0; eret_req = 1'b0; epc = '0;

    //   stall br  target        exc eret epc           exp_pc        pend fexc
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 0, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 0, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 0, 0);
    add(1, 1, 32'h3100,      0, 0, 32'h0,         32'h0000_300C, 1, 0);
    add(1, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 1, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3100, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3104, 0, 0);
    add(1, 1, 32'h3200,      0, 0, 32'h0,         32'h0000_3104, 1, 0);
    add(1, 1, 32'h3300,      0, 0, 32'h0,         32'h0000_3104, 1, 0);
    add(0, 1, 32'h3400,      0, 0, 32'h0,         32'h0000_3400, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3404, 0, 0);
    add(1, 1, 32'h3500,      0, 0, 32'h0,         32'h0000_3404, 1, 0);
    add(1, 0, 32'h0,         1, 1, 32'h3010,      32'h0000_4180, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 0, 0);
    add(0, 0, 32'h0,         0, 1, 32'h3002,      32'h0000_3002, 0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3006, 0, 1);
    add(0, 0, 32'h0,         0, 1, 32'h8000,      32'h0000_8000, 0, 1);
    add(0, 0, 32'h0,         0, 1, 32'h6FFC,      32'h0000_6FFC, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7000, 0, 1);
    add(0, 1, 32'h2FFC,      0, 0, 32'h0,         32'h0000_2FFC, 0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 0, 0);
    add(0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0,         32'hFFFF_FFFC, 0, 1);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_0000, 0, 1);
    add(1, 0, 32'h0,         0, 1, 32'h3020,      32'h0000_3020, 0, 0);
    add(1, 1, 32'h3600,      0, 0, 32'h0,         32'h0000_3020, 1, 0);
    add(1, 0, 32'h0,         0, 1, 32'h3030,      32'h0000_3030, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3034, 0, 0);
    add(0, 1, 32'h3800,      1, 0, 32'h0,         32'h0000_4180, 0, 0);
    add(0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_4184, 0, 0);
    add(1, 1, 32'h3700,      0, 0, 32'h0,         32'h0000_4184, 1, 0);

    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 32'h0000_3000, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset     = 1'b0;
      stall     = vecs[i].stall;
      br_req    = vecs[i].br;
      br_target = vecs[i].tgt;
      exc_req   = vecs[i].exc;
      eret_req  = vecs[i].eret;
      epc       = vecs[i].epc;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pend, vecs[i].exp_fexc);
    end

    // Reset while stalled with a buffered branch: buffer must not survive.
    @(negedge clk);
    reset = 1'b1; stall = 1'b1; br_req = 1'b0; exc_req = 1'b0; eret_req = 1'b0;
    @(posedge clk);
    #1;
    check_all("reset_in_pend", 32'h0000_3000, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0; stall = 1'b0;
    @(posedge clk);
    #1;
    check_all("after_reset", 32'h0000_3004, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check_all("after_reset2", 32'h0000_3008, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
